// File: rtl/i2s_dac_serializer.sv
// i2s_dac_serializer: generates bclk/lrclk and shifts latched L/R samples MSB-first on dacdat.
// Build with I2S_DELAY_EN for Philips I2S (data one bclk after lrclk); default is left-justified.
module i2s_dac_serializer #(
   parameter int BCLK_DIV     = 8,
   parameter int SAMPLE_WIDTH = 24,
   parameter int SLOT_BITS    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SAMPLE_WIDTH-1:0] left_sample,
   input  logic [SAMPLE_WIDTH-1:0] right_sample,
   output logic                    sample_req,
   output logic                    bclk,
   output logic                    lrclk,
   output logic                    dacdat
);
   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int CW = $clog2(2 * SLOT_BITS);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * SLOT_BITS - 1);
   localparam logic [CW-1:0] SLOT_L   = CW'(SLOT_BITS);
   localparam logic [CW-1:0] SW_L     = CW'(SAMPLE_WIDTH);

   logic [DW-1:0]           div;
   logic [CW-1:0]           bit_cnt;
   logic [SAMPLE_WIDTH-1:0] left_sh;
   logic [SAMPLE_WIDTH-1:0] right_sh;

   logic                    tick;
   logic                    fall;
   logic                    frame_start;
   logic                    right_next;
   logic [CW-1:0]           bit_next;
   logic [CW-1:0]           pos;
   logic [SAMPLE_WIDTH-1:0] src;
   logic [SAMPLE_WIDTH-1:0] shifted;
   logic                    data_bit;

   // No handshake: sample_req is an informational strobe, upstream must already
   // hold valid samples on the edge it is raised; there is no backpressure path.
   always_comb begin
      tick        = (div == DIV_LAST);
      fall        = tick && bclk;
      bit_next    = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
      frame_start = (bit_next == '0);
      right_next  = (bit_next >= SLOT_L);
      pos         = right_next ? (bit_next - SLOT_L) : bit_next;
      // On a frame start the shadows are being loaded, so take the live input.
      if (frame_start)
         src = left_sample;
      else
         src = right_next ? right_sh : left_sh;
      shifted  = '0;
      data_bit = 1'b0;
`ifdef I2S_DELAY_EN
      if (pos != '0 && pos <= SW_L) begin
         shifted  = src << (pos - 1'b1);
         data_bit = shifted[SAMPLE_WIDTH-1];
      end
`else
      if (pos < SW_L) begin
         shifted  = src << pos;
         data_bit = shifted[SAMPLE_WIDTH-1];
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div        <= '0;
         bit_cnt    <= CNT_LAST;
         left_sh    <= '0;
         right_sh   <= '0;
         bclk       <= 1'b0;
         lrclk      <= 1'b1;
         dacdat     <= 1'b0;
         sample_req <= 1'b0;
      end else begin
         div        <= tick ? '0 : div + 1'b1;
         sample_req <= fall && frame_start;
         if (tick)
            bclk <= ~bclk;
         if (fall) begin
            bit_cnt <= bit_next;
            lrclk   <= right_next;
            dacdat  <= data_bit;
            if (frame_start) begin
               left_sh  <= left_sample;
               right_sh <= right_sample;
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: arithmetic timing model plus directed and random frames.
module tb_i2s_dac_serializer;
   localparam int D     = 2;
   localparam int S     = 32;
   localparam int W     = 24;
   localparam int FRAME = 4 * D * S;

`ifdef I2S_DELAY_EN
   localparam logic [63:0] LJ_EXP   = 64'h7F800000_007FFF80;
   localparam logic [31:0] MID1_EXP = 32'h40000080;
   localparam logic [31:0] MID2_EXP = 32'h3FFFFF00;
`else
   localparam logic [63:0] LJ_EXP   = 64'hFF000000_00FFFF00;
   localparam logic [31:0] MID1_EXP = 32'h80000100;
   localparam logic [31:0] MID2_EXP = 32'h7FFFFE00;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] left_sample = '0;
   logic [W-1:0] right_sample = '0;
   logic         sample_req;
   logic         bclk;
   logic         lrclk;
   logic         dacdat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   i2s_dac_serializer #(.BCLK_DIV(D), .SAMPLE_WIDTH(W), .SLOT_BITS(S)) dut (
      .clk(clk), .rst(rst), .left_sample(left_sample), .right_sample(right_sample),
      .sample_req(sample_req), .bclk(bclk), .lrclk(lrclk), .dacdat(dacdat)
   );

   // Reference: everything follows from n = clk edges since reset release.
   int           n = 0;
   logic [W-1:0] m_left = '0;
   logic [W-1:0] m_right = '0;

   function automatic bit is_fs(int e);
      return (e > 0) && (e % (2 * D) == 0) && (((e / (2 * D) - 1) % (2 * S)) == 0);
   endfunction

   function automatic int cnt_of(int e);
      return (e / (2 * D) == 0) ? 2 * S - 1 : (e / (2 * D) - 1) % (2 * S);
   endfunction

   function automatic logic bit_at(logic [W-1:0] s, int p);
`ifdef I2S_DELAY_EN
      if (p >= 1 && p <= W) return s[W-p];
`else
      if (p < W) return s[W-1-p];
`endif
      return 1'b0;
   endfunction

   function automatic logic [63:0] frame_bits(logic [W-1:0] l, logic [W-1:0] r);
      logic [63:0] b = '0;
      for (int p = 0; p < S; p++) begin
         b[2*S-1-p] = bit_at(l, p);
         b[S-1-p]   = bit_at(r, p);
      end
      return b;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n       <= 0;
         m_left  <= '0;
         m_right <= '0;
      end else begin
         n <= n + 1;
         if (is_fs(n + 1)) begin
            m_left  <= left_sample;
            m_right <= right_sample;
         end
      end
   end

   function automatic logic exp_bclk();
      return logic'((n / D) % 2);
   endfunction

   function automatic logic exp_lrclk();
      return cnt_of(n) >= S;
   endfunction

   function automatic logic exp_dat();
      int c = cnt_of(n);
      if (n / (2 * D) == 0) return 1'b0;
      return bit_at((c >= S) ? m_right : m_left, c % S);
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int          cyc = 0;
   int          last_req = -1;
   int          cap_cnt = 64;
   logic [63:0] cap = '0;
   logic        prev_bclk = 1'b0;
   logic        prev_lr = 1'b1;

   task automatic tick();
      @(negedge clk);
      cyc++;
      chk("bclk", bclk, exp_bclk());
      chk("lrclk", lrclk, exp_lrclk());
      chk("dacdat", dacdat, exp_dat());
      chk("sample_req", sample_req, is_fs(n));
      if (rst) last_req = -1;
      if (sample_req === 1'b1) begin
         if (last_req >= 0) chk("req_spacing", cyc - last_req, FRAME);
         chk("req_lrclk_fall", {prev_lr, lrclk}, 2'b10);
         last_req = cyc;
         cap_cnt  = 0;
      end
      if (bclk === 1'b1 && prev_bclk === 1'b0 && cap_cnt < 64) begin
         cap[63-cap_cnt] = dacdat;
         cap_cnt++;
      end
      prev_bclk = bclk;
      prev_lr   = lrclk;
   endtask

   task automatic tick_n(int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic wait_req(int max, output int waited);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (sample_req !== 1'b1 && waited < max);
      if (sample_req !== 1'b1) chk("req_timeout", sample_req, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int           w;
      int           w2;
      int           k;
      logic [W-1:0] l;
      logic [W-1:0] r;

      // Reset held from time zero, then release with the directed pattern.
      tick_n(3);
      chk("rst_bclk", bclk, 1'b0);
      chk("rst_lrclk", lrclk, 1'b1);
      chk("rst_dacdat", dacdat, 1'b0);
      chk("rst_req", sample_req, 1'b0);
      left_sample  = 24'hFF0000;
      right_sample = 24'h00FFFF;
      rst = 1'b0;
      w = 0;
      while (bclk !== 1'b1 && w < 10) begin
         tick();
         w++;
      end
      chk("first_bclk_rise_edge", w, D);
      wait_req(10, w2);
      chk("first_req_edge", w + w2, 2 * D);
      tick_n(FRAME - 1);
      chk("lj_frame", cap, LJ_EXP);

      // Input change in the middle of a left slot must not reach the current frame.
      left_sample = 24'h800001;
      wait_req(FRAME + 4, w2);
      chk("req_period", w2, 1);
      tick_n(22);
      left_sample = 24'h7FFFFE;
      tick_n(FRAME - 1 - 22);
      chk("mid_cur_left", cap[63:32], MID1_EXP);
      wait_req(4, w2);
      tick_n(FRAME - 1);
      chk("mid_next_left", cap[63:32], MID2_EXP);

      // Random frames with random inputs disturbed partway through.
      for (int f = 0; f < 6; f++) begin
         l = W'($urandom);
         r = W'($urandom);
         left_sample  = l;
         right_sample = r;
         wait_req(FRAME + 4, w2);
         k = $urandom_range(1, 200);
         tick_n(k);
         left_sample  = W'($urandom);
         right_sample = W'($urandom);
         tick_n(FRAME - 1 - k);
         chk("rand_frame", cap, frame_bits(l, r));
      end

      // Asynchronous reset at bit 40, held across 3 clk edges.
      wait_req(FRAME + 4, w2);
      tick_n(4 * 40 + 1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_bclk", bclk, 1'b0);
      chk("async_rst_lrclk", lrclk, 1'b1);
      chk("async_rst_dacdat", dacdat, 1'b0);
      chk("async_rst_req", sample_req, 1'b0);
      tick_n(3);
      l = W'($urandom);
      r = W'($urandom);
      left_sample  = l;
      right_sample = r;
      rst = 1'b0;
      wait_req(2 * D + 4, w2);
      chk("req_after_rst", w2, 2 * D);
      tick_n(FRAME - 1);
      chk("post_rst_frame", cap, frame_bits(l, r));
      tick_n(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
